// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
//   state_e      : fetch FSM state (IDLE / RUN)
//   INSTR_W      : instruction word width
//   RESET_PC_DEF : default PC loaded on reset
//   PC_STEP      : byte increment between sequential fetches
package fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/instr_mem.sv
// Synchronous instruction memory, 2^ADDR_W x INSTR_W.
//   clk, rst_n      : clock, async active-low reset (read register only)
//   re_i, raddr_i   : read enable / word address; data lands in rdata_o
//                     after the edge and is held while re_i is low
//   we_i, waddr_i,
//   wdata_i         : loader write port
// A read and write to the same word in one cycle returns the old word.
module instr_mem
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               re_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [INSTR_W-1:0] rdata_o,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [INSTR_W-1:0] wdata_i
);

  logic [INSTR_W-1:0] mem_q [2**ADDR_W];
  logic [INSTR_W-1:0] rdata_q;

  // Array is not reset; contents are whatever the loader put there.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // The read register doubles as the presented instruction, so it is
  // reset to zero and held when no read is issued (stall).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end for the mini-MIPS core.
//   clk, rst_n        : clock, async active-low reset
//   fetch_en          : run enable (low parks the unit in IDLE)
//   imem_we/waddr/
//   wdata             : loader write port into instruction memory
//   redirect_valid/pc : taken branch/jump target from the core
//   instr_ready       : core accepts the presented instruction
//   instr_valid,
//   instruction,
//   instr_pc          : presented instruction and its byte PC
//   fetch_err         : sticky misaligned-redirect / out-of-range PC flag
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               imem_we,
  input  logic [ADDR_W-1:0]  imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               instr_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [31:0]        instr_pc,
  output logic               fetch_err
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ipc_q, ipc_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;
  logic        slot_free, issue;

  // ---- FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_en)  state_d = RUN;
      RUN:     if (!fetch_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs (issue decision)
  always_comb begin
    slot_free = !vld_q || instr_ready;
    issue     = (state_q == RUN) && fetch_en && !redirect_valid && slot_free;
  end

  // ---- Datapath next state
  always_comb begin
    pc_d  = pc_q;
    ipc_d = ipc_q;
    vld_d = vld_q;
    err_d = err_q;
    if (redirect_valid) begin
      // Redirect wins over issue; a same-cycle handshake of the
      // presented instruction still counts as consumed.
      pc_d  = {redirect_pc[31:2], 2'b00};
      vld_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) err_d = 1'b1;
    end else if (issue) begin
      pc_d  = pc_q + PC_STEP;
      ipc_d = pc_q;
      vld_d = 1'b1;
      // PC beyond memory: index wraps but the fetch still completes.
      if ((pc_q >> (ADDR_W + 2)) != 32'd0) err_d = 1'b1;
    end else if (slot_free) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ipc_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ipc_q <= ipc_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  // Memory read register holds the presented instruction word.
  instr_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .re_i    (issue),
    .raddr_i (pc_q[ADDR_W+1:2]),
    .rdata_o (instruction),
    .we_i    (imem_we),
    .waddr_i (imem_waddr),
    .wdata_i (imem_wdata)
  );

  assign instr_valid = vld_q;
  assign instr_pc    = ipc_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, imem_we, redirect_valid, instr_ready;
  logic [9:0]  imem_waddr;
  logic [31:0] imem_wdata, redirect_pc;
  logic        instr_valid, fetch_err;
  logic [31:0] instruction, instr_pc;
  // Small-memory instance (ADDR_W=4) sharing the same stimulus.
  logic        w_valid, w_err;
  logic [31:0] w_instr, w_pc;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(10), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_ready(instr_ready), .instr_valid(instr_valid),
    .instruction(instruction), .instr_pc(instr_pc), .fetch_err(fetch_err));

  instr_fetch_unit #(.ADDR_W(4), .RESET_PC(32'h0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_we(imem_we),
    .imem_waddr(imem_waddr[3:0]), .imem_wdata(imem_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_ready(instr_ready), .instr_valid(w_valid),
    .instruction(w_instr), .instr_pc(w_pc), .fetch_err(w_err));

  function automatic logic [31:0] word_at(input int idx);
    case (idx)
      0:  return 32'h0022_1820;
      1:  return 32'h0062_1818;
      2:  return 32'h7462_1800;
      3:  return 32'hFC00_0000;
      15: return 32'hDEAD_000F;
      default: return 32'hA000_0000 | idx;
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 0; imem_we = 0; redirect_valid = 0;
    instr_ready = 0; imem_waddr = '0; imem_wdata = '0; redirect_pc = '0;
    #2;
    n_chk++;
    if ({instr_valid, instr_pc, instruction, fetch_err} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset got v=%b pc=%h ins=%h err=%b want all 0",
               instr_valid, instr_pc, instruction, fetch_err);
    end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic load_program();
    for (int i = 0; i < 16; i++) begin
      if (i < 8 || i == 15) begin
        imem_we = 1; imem_waddr = 10'(i); imem_wdata = word_at(i);
        step();
      end
    end
    imem_we = 0;
  endtask

  task automatic test_stream();
    fetch_en = 1; instr_ready = 1;
    step();  // IDLE -> RUN
    n_chk++;
    if (instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL start_lat got v=%b want 0", instr_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++;
      if ({instr_valid, instr_pc, instruction} !== {1'b1, 32'(i * 4), word_at(i)}) begin
        n_fail++;
        $display("FAIL stream%0d got v=%b pc=%h ins=%h want 1/%h/%h",
                 i, instr_valid, instr_pc, instruction, 32'(i * 4), word_at(i));
      end
    end
    fetch_en = 0;
    step();  // RUN -> IDLE, slot drains
    n_chk++;
    if (instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL stop got v=%b want 0", instr_valid);
    end
  endtask

  task automatic test_stall();
    redirect_valid = 1; redirect_pc = 32'h0; fetch_en = 1; instr_ready = 1;
    step();
    redirect_valid = 0;
    step();  // 0x0 presented
    step();  // 0x4 presented
    n_chk++;
    if ({instr_valid, instr_pc, instruction} !== {1'b1, 32'h4, 32'h0062_1818}) begin
      n_fail++; $display("FAIL stall_pre got v=%b pc=%h ins=%h want 1/4/00621818",
                         instr_valid, instr_pc, instruction);
    end
    instr_ready = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if ({instr_valid, instr_pc, instruction} !== {1'b1, 32'h4, 32'h0062_1818}) begin
        n_fail++; $display("FAIL stall_hold%0d got v=%b pc=%h ins=%h want 1/4/00621818",
                           k, instr_valid, instr_pc, instruction);
      end
    end
    instr_ready = 1;
    step();
    n_chk++;
    if ({instr_valid, instr_pc, instruction} !== {1'b1, 32'h8, 32'h7462_1800}) begin
      n_fail++; $display("FAIL stall_release got v=%b pc=%h ins=%h want 1/8/74621800",
                         instr_valid, instr_pc, instruction);
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1; redirect_pc = 32'h4;
    step();
    redirect_valid = 0;
    step();  // 0x4 presented, accepted next edge together with redirect
    redirect_valid = 1; redirect_pc = 32'h10;
    step();
    n_chk++;
    if ({instr_valid, fetch_err} !== 2'b00) begin
      n_fail++; $display("FAIL redir_bubble got v=%b err=%b want 0/0", instr_valid, fetch_err);
    end
    redirect_valid = 0;
    step();
    n_chk++;
    if ({instr_valid, instr_pc, instruction} !== {1'b1, 32'h10, 32'hA000_0004}) begin
      n_fail++; $display("FAIL redir_target got v=%b pc=%h ins=%h want 1/10/a0000004",
                         instr_valid, instr_pc, instruction);
    end
    step();
    n_chk++;
    if ({instr_valid, instr_pc, instruction} !== {1'b1, 32'h14, 32'hA000_0005}) begin
      n_fail++; $display("FAIL redir_next got v=%b pc=%h ins=%h want 1/14/a0000005",
                         instr_valid, instr_pc, instruction);
    end
  endtask

  task automatic test_misalign();
    redirect_valid = 1; redirect_pc = 32'h13;
    step();
    n_chk++;
    if ({instr_valid, fetch_err} !== 2'b01) begin
      n_fail++; $display("FAIL misalign_err got v=%b err=%b want 0/1", instr_valid, fetch_err);
    end
    redirect_valid = 0;
    step();
    n_chk++;
    if ({instr_valid, instr_pc, fetch_err} !== {1'b1, 32'h10, 1'b1}) begin
      n_fail++; $display("FAIL misalign_fetch got v=%b pc=%h err=%b want 1/10/1",
                         instr_valid, instr_pc, fetch_err);
    end
    step();
    n_chk++;
    if ({instr_valid, instr_pc, fetch_err} !== {1'b1, 32'h14, 1'b1}) begin
      n_fail++; $display("FAIL misalign_sticky got v=%b pc=%h err=%b want 1/14/1",
                         instr_valid, instr_pc, fetch_err);
    end
  endtask

  task automatic test_idle_drain();
    fetch_en = 0; instr_ready = 0;
    step();
    n_chk++;
    if ({instr_valid, instr_pc, instruction} !== {1'b1, 32'h14, 32'hA000_0005}) begin
      n_fail++; $display("FAIL drain_hold got v=%b pc=%h ins=%h want 1/14/a0000005",
                         instr_valid, instr_pc, instruction);
    end
    instr_ready = 1;
    step();
    n_chk++;
    if (instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_release got v=%b want 0", instr_valid);
    end
  endtask

  task automatic test_reset_mid();
    fetch_en = 1; instr_ready = 1;
    step();
    step();  // 0x18 presented
    n_chk++;
    if ({instr_valid, instr_pc} !== {1'b1, 32'h18}) begin
      n_fail++; $display("FAIL pre_reset got v=%b pc=%h want 1/18", instr_valid, instr_pc);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({instr_valid, instr_pc, instruction, fetch_err} !== 66'd0) begin
      n_fail++; $display("FAIL reset_mid got v=%b pc=%h ins=%h err=%b want all 0",
                         instr_valid, instr_pc, instruction, fetch_err);
    end
    step();
    rst_n = 1'b1;
    step();  // IDLE -> RUN
    step();
    n_chk++;
    if ({instr_valid, instr_pc, instruction} !== {1'b1, 32'h0, 32'h0022_1820}) begin
      n_fail++; $display("FAIL restart got v=%b pc=%h ins=%h want 1/0/00221820",
                         instr_valid, instr_pc, instruction);
    end
  endtask

  task automatic test_wrap();
    fetch_en = 0;
    step();
    redirect_valid = 1; redirect_pc = 32'h3C;
    step();
    redirect_valid = 0; fetch_en = 1;
    step();  // IDLE -> RUN
    step();
    n_chk++;
    if ({w_valid, w_pc, w_instr, w_err} !== {1'b1, 32'h3C, 32'hDEAD_000F, 1'b0}) begin
      n_fail++; $display("FAIL wrap_last got v=%b pc=%h ins=%h err=%b want 1/3c/dead000f/0",
                         w_valid, w_pc, w_instr, w_err);
    end
    step();
    n_chk++;
    if ({w_valid, w_pc, w_instr, w_err} !== {1'b1, 32'h40, 32'h0022_1820, 1'b1}) begin
      n_fail++; $display("FAIL wrap_over got v=%b pc=%h ins=%h err=%b want 1/40/00221820/1",
                         w_valid, w_pc, w_instr, w_err);
    end
    n_chk++;
    if (fetch_err !== 1'b0) begin
      n_fail++; $display("FAIL wrap_bigmem_err got %b want 0", fetch_err);
    end
  endtask

  initial begin
    test_reset();
    load_program();
    test_stream();
    test_stall();
    test_redirect();
    test_misalign();
    test_idle_drain();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front-end that feeds the `instruction` input of the mini-MIPS core. It holds the PC, reads a synchronous on-chip instruction memory, and presents one 32-bit instruction per cycle on a valid/ready handshake. It takes branch/jump redirects from the core and has a loader write port so benches and boot logic can preload programs.

## Interface
- `ADDR_W`, 10, word-address width of instruction memory (depth 2^ADDR_W words)
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `clk` in 1, single clock, rising edge
- `rst_n` in 1, asynchronous active-low reset
- `fetch_en` in 1, run enable; low parks the unit in IDLE
- `imem_we` in 1, loader write strobe
- `imem_waddr` in ADDR_W, loader word address
- `imem_wdata` in 32, loader write data
- `redirect_valid` in 1, core requests PC change (taken branch/jump)
- `redirect_pc` in 32, new byte PC
- `instr_ready` in 1, core accepts the presented instruction
- `instr_valid` out 1, `instruction`/`instr_pc` are valid
- `instruction` out 32, fetched instruction word
- `instr_pc` out 32, byte PC of `instruction`
- `fetch_err` out 1, sticky: misaligned redirect or out-of-range PC seen

## Operation
- States: IDLE, RUN.
- IDLE→RUN when `fetch_en`=1 at an edge. RUN→IDLE when `fetch_en`=0 at an edge.
- Issue condition: state RUN, `fetch_en`=1, `redirect_valid`=0, and the output slot is free (`!instr_valid || instr_ready`).
- On issue: read `mem[pc[ADDR_W+1:2]]`; capture `instruction`<=data, `instr_pc`<=pc, `instr_valid`<=1; pc<=pc+4 (32-bit wrap).
- Output slot free but no issue: `instr_valid`<=0.
- Stall (`instr_valid && !instr_ready`): `instruction`, `instr_pc`, `instr_valid` and pc are all held.
- Redirect, in any state: pc<={redirect_pc[31:2],2'b00}; `instr_valid`<=0. The instruction is flushed unless it is handshaken in the same cycle; that handshake counts as consumed. Redirect beats issue. In IDLE it only updates pc.
- `fetch_err` is set, sticky until reset, when:
  - `redirect_pc[1:0]`≠0, or
  - an issued pc has nonzero bits [31:ADDR_W+2]. The memory index wraps modulo depth; the fetch still completes.
- Leaving RUN while `instr_valid`=1: the instruction stays presented until it is accepted, then `instr_valid`<=0.
- Loader write is always accepted regardless of state.
- Same-cycle write and read of one address: the read returns the old word.

## Timing
- Reset (async assert, sync deassert by design intent) sets:
  - state=IDLE, pc=RESET_PC
  - `instr_valid`=0, `instruction`=0, `instr_pc`=0, `fetch_err`=0
  - memory contents are undefined (not reset).
- Reset mid-RUN drops any presented instruction immediately.
- Start latency: `fetch_en` high at edge 0 → RUN. First issue at edge 1, so `instr_valid`=1 after edge 1.
- Throughput: 1 instruction per cycle while `instr_ready`=1.
- Redirect penalty: redirect sampled at edge N → bubble after N → target instruction valid after edge N+1.
- Stall release: `instr_ready` rising at a cycle with `instr_valid`=1 → next instruction valid after the following edge (no bubble).
- `fetch_err` is visible the cycle after the offending edge.

## Structure
- Package `fetch_pkg`:
  - state enum (IDLE, RUN)
  - `INSTR_W`=32
  - default `RESET_PC`
  - `PC_STEP`=4
- Sub-module `instr_mem`: 2^ADDR_W×32, one synchronous read port (read enable, read address, registered data) and one write port, read-old-on-collision.
- Top holds the FSM, pc, output/valid registers and error flag.

## Test plan
- Load words 0..3 = 0x00221820, 0x00621818, 0x74621800, 0xFC000000; `fetch_en`=1, `instr_ready`=1 → these four words appear on consecutive cycles with `instr_pc` 0x0, 0x4, 0x8, 0xC; first valid one cycle after RUN entry.
- Stall: hold `instr_ready`=0 for 3 cycles while the word at 0x4 is presented → `instruction`=0x00621818 is held for all 3 cycles, pc does not advance, and 0x8 follows with no bubble after release.
- Redirect to 0x10 in the same cycle 0x4 is accepted → 0x4 is counted consumed, one bubble, then word 0x10 with `instr_pc`=0x10, then 0x14.
- Redirect to 0x13 → `fetch_err`=1 the next cycle and stays 1; the fetch proceeds from 0x10.
- With ADDR_W=4, run past 0x3C to 0x40 → the word at index 0 is returned, `instr_pc`=0x40, `fetch_err`=1.
- Assert `rst_n`=0 mid-stream with `instr_valid`=1 → `instr_valid`, `instruction`, `instr_pc` drop to 0 immediately; after release with `fetch_en`=1, fetch restarts at RESET_PC.
